// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serial transmitter.
// The core pushes bytes with a single-cycle strobe; the transmitter drains
// the FIFO back-to-back with no idle gap between frames.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                uart_dout,
  input  logic                       uart_we,
  output logic                       txd,
  output logic                       busy,
  output logic                       full,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
  output logic                       overflow
);

  localparam int                     DEPTH     = 1 << FIFO_DEPTH_LOG2;
  localparam logic [15:0]            BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]            BAUD_ONE  = 16'd1;
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE  = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                     state_q;
  logic [15:0]                baud_q;
  logic [2:0]                 bit_idx_q;
  logic [7:0]                 shift_q;
  logic                       txd_q;

  logic [7:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q;
  logic [FIFO_DEPTH_LOG2:0]   count_d;
  logic                       overflow_q;

  logic                       baud_last;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       pop;
  logic                       push_ok;

  // Only the low byte of the write port carries character data.
  logic                       unused_dout;
  assign unused_dout = ^uart_dout[31:8];

  assign baud_last  = (baud_q == BAUD_LAST);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);

  // A pop happens when the line is free: idle, or the final cycle of a stop bit.
  assign pop     = !fifo_empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_last));
  // A full FIFO still accepts a push when a slot frees on the same edge.
  assign push_ok = uart_we && (!fifo_full || pop);

  // Next occupancy: push and pop on the same edge cancel out.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      if (uart_we && !push_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage; the read side is registered into the shift register by the FSM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= uart_dout[7:0];
    end
  end

  // Frame sequencer: start bit, eight data bits LSB first, stop bit, with registered txd.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          txd_q  <= 1'b1;
          baud_q <= '0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= S_START;
            txd_q   <= 1'b0;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
            txd_q     <= shift_q[0];
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
              txd_q   <= 1'b1;
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              state_q <= S_START;
              txd_q   <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              txd_q   <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign txd        = txd_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign full       = fifo_full;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios plus random pushes, checked every cycle
// against a frame-position model of the transmitter and a queue for the FIFO.
module tb_uart_tx_fifo;

  localparam int C = 4;
  localparam int L = 2;
  localparam int D = 1 << L;
  localparam int FRAME = 10 * C;

  logic         clk;
  logic         reset;
  logic [31:0]  uart_dout;
  logic         uart_we;
  logic         txd;
  logic         busy;
  logic         full;
  logic [L:0]   fifo_count;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes waiting, position inside the current frame (-1 = line idle).
  logic [7:0] m_q [$];
  int         m_t;
  logic [7:0] m_cur;
  logic       m_ovf;

  uart_tx_fifo #(
    .CLKS_PER_BIT    (C),
    .FIFO_DEPTH_LOG2 (L)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_dout  (uart_dout),
    .uart_we    (uart_we),
    .txd        (txd),
    .busy       (busy),
    .full       (full),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_txd();
    int bi;
    if (m_t < 0) return 1'b1;
    bi = m_t / C;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return m_cur[bi-1];
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_t   = -1;
    m_cur = 8'h00;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic we, input logic [31:0] din);
    bit pop_now;
    bit room;
    pop_now = (m_t < 0 || m_t == FRAME - 1) && (m_q.size() != 0);
    room    = (m_q.size() < D) || pop_now;
    if (pop_now) begin
      m_cur = m_q.pop_front();
      m_t   = 0;
    end else if (m_t >= 0) begin
      m_t++;
      if (m_t == FRAME) m_t = -1;
    end
    if (we) begin
      if (room) begin
        m_q.push_back(din[7:0]);
        $display("push %02h accepted, queued=%0d", din[7:0], m_q.size());
      end else begin
        m_ovf = 1'b1;
        $display("push %02h dropped (fifo full)", din[7:0]);
      end
    end
  endtask

  task automatic compare_all();
    check("txd",   txd,        exp_txd());
    check("busy",  busy,       (m_t >= 0) || (m_q.size() != 0));
    check("full",  full,       m_q.size() == D);
    check("count", fifo_count, m_q.size());
    check("ovf",   overflow,   m_ovf);
  endtask

  // One clock: drive inputs at the falling edge, model the rising edge, sample 1 ns later.
  task automatic tick(input logic we, input logic [31:0] din);
    uart_we   = we;
    uart_dout = din;
    @(posedge clk);
    model_step(we, din);
    #1;
    uart_we   = 1'b0;
    uart_dout = 32'h0;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0);
  endtask

  // Assert reset between clock edges; txd must rise before any edge arrives.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check("rst_txd",   txd,        1'b1);
    check("rst_busy",  busy,       1'b0);
    check("rst_full",  full,       1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf",   overflow,   1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int   reached;
    reset     = 1'b0;
    uart_we   = 1'b0;
    uart_dout = 32'h0;
    model_clear();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b1;
    idle(3);

    // 1. single byte
    tick(1'b1, 32'h0000_0055);
    idle(FRAME + 5);

    // 2. upper write bits ignored
    tick(1'b1, 32'hDEAD_BE41);
    idle(FRAME + 5);

    // 3. back-to-back frames
    tick(1'b1, 32'h0000_00A5);
    tick(1'b1, 32'h0000_003C);
    idle(2 * FRAME + 5);

    // 4. overflow while a frame is in flight
    tick(1'b1, 32'h0000_0010);
    idle(3);
    for (int i = 1; i <= 5; i++) tick(1'b1, 32'(i));
    check("s4_count", fifo_count, 4);
    check("s4_full",  full,       1'b1);
    check("s4_ovf",   overflow,   1'b1);
    idle(5 * FRAME + 5);

    // 5. push into a full FIFO on the pop edge
    async_reset();
    tick(1'b1, 32'h0000_0011);
    for (int i = 0; i < 4; i++) tick(1'b1, 32'h20 + 32'(i));
    reached = 0;
    for (int i = 0; i < 3 * FRAME && reached == 0; i++) begin
      if (m_t == FRAME - 1) reached = 1;
      else tick(1'b0, 32'h0);
    end
    check("s5_reach", reached, 1);
    tick(1'b1, 32'h0000_0077);
    check("s5_count", fifo_count, 4);
    check("s5_ovf",   overflow,   1'b0);
    idle(5 * FRAME + 5);

    // 6. reset during data bit 3, with a dropped push already flagged
    tick(1'b1, 32'h0000_0000);
    for (int i = 0; i < 5; i++) tick(1'b1, 32'hF0 + 32'(i));
    reached = 0;
    for (int i = 0; i < FRAME && reached == 0; i++) begin
      if (m_t == 4 * C + 1) reached = 1;
      else tick(1'b0, 32'h0);
    end
    check("s6_reach", reached, 1);
    check("s6_pre_txd", txd, 1'b0);
    async_reset();
    idle(20);
    tick(1'b1, 32'h0000_00C3);
    idle(FRAME + 5);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) tick(1'b1, $urandom);
      else tick(1'b0, 32'h0);
      if (i == 1500) async_reset();
    end
    idle(6 * FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
